uc_pipe_regs: RTL



---
 rtl/uc_pipe_regs.sv | 128 ++++++++++++
 1 files changed

// File: rtl/uc_pipe_regs.sv
// uc_pipe_regs: control-word register chain for stages 2..5 of the microcoded
// core. Stage 2 captures fetched microinstruction fields. Stages 3..5 carry
// only the destination and control fields forward. HOLD freezes stage 2 and
// inserts bubbles into stage 3. flush kills the younger stages.
// Also keeps stall/retire statistics and a sticky stuck-HOLD flag.
module uc_pipe_regs #(
    parameter int CNT_W    = 16,
    parameter int HOLD_MAX = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             f_valid,
    input  logic [4:0]       f_A,
    input  logic [5:0]       f_B,
    input  logic [5:0]       f_C,
    input  logic [6:0]       f_T,
    input  logic             HOLD,
    input  logic             flush,
    output logic [4:0]       A2,
    output logic [5:0]       B2,
    output logic [6:0]       T2,
    output logic [5:0]       C3,
    output logic [6:0]       T3,
    output logic [5:0]       C4,
    output logic [6:0]       T4,
    output logic [5:0]       C5,
    output logic [6:0]       T5,
    output logic             v2,
    output logic             v3,
    output logic             v4,
    output logic             v5,
    output logic             fetch_stall,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             hold_err
);

    localparam int RUN_W = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(HOLD_MAX - 1);

    logic             r_v2, r_v3, r_v4, r_v5;
    logic [4:0]       r_A2;
    logic [5:0]       r_B2, r_C2, r_C3, r_C4, r_C5;
    logic [6:0]       r_T2, r_T3, r_T4, r_T5;
    logic [CNT_W-1:0] r_stall_cnt, r_retire_cnt;
    logic [RUN_W-1:0] r_hold_run;
    logic             r_hold_err;

    // A HOLD that coincides with a flush is treated as a flush.
    logic w_stall;
    assign w_stall = HOLD & ~flush;

    // Stage advance: flush kills 2..4 while the old stage-4 word still
    // reaches stage 5. HOLD freezes stage 2 and bubbles stage 3.
    always_ff @(posedge clk) begin
        if (reset) begin
            {r_v2, r_A2, r_B2, r_C2, r_T2} <= '0;
            {r_v3, r_C3, r_T3}             <= '0;
            {r_v4, r_C4, r_T4}             <= '0;
            {r_v5, r_C5, r_T5}             <= '0;
        end else if (flush) begin
            {r_v2, r_A2, r_B2, r_C2, r_T2} <= '0;
            {r_v3, r_C3, r_T3}             <= '0;
            {r_v4, r_C4, r_T4}             <= '0;
            {r_v5, r_C5, r_T5}             <= {r_v4, r_C4, r_T4};
        end else if (HOLD) begin
            {r_v3, r_C3, r_T3}             <= '0;
            {r_v4, r_C4, r_T4}             <= {r_v3, r_C3, r_T3};
            {r_v5, r_C5, r_T5}             <= {r_v4, r_C4, r_T4};
        end else begin
            if (f_valid)
                {r_v2, r_A2, r_B2, r_C2, r_T2} <= {1'b1, f_A, f_B, f_C, f_T};
            else
                {r_v2, r_A2, r_B2, r_C2, r_T2} <= '0;
            {r_v3, r_C3, r_T3}             <= {r_v2, r_C2, r_T2};
            {r_v4, r_C4, r_T4}             <= {r_v3, r_C3, r_T3};
            {r_v5, r_C5, r_T5}             <= {r_v4, r_C4, r_T4};
        end
    end

    // Statistics: saturating stall count, wrapping retire count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt  <= '0;
            r_retire_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (r_v5)
                r_retire_cnt <= r_retire_cnt + 1'b1;
        end
    end

    // Stuck-HOLD detector. The run counter parks at HOLD_MAX-1, which is
    // enough to know the limit has been reached.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_run <= '0;
            r_hold_err <= 1'b0;
        end else if (w_stall) begin
            if (r_hold_run == RUN_LAST)
                r_hold_err <= 1'b1;
            else
                r_hold_run <= r_hold_run + 1'b1;
        end else begin
            r_hold_run <= '0;
        end
    end

    assign A2          = r_A2;
    assign B2          = r_B2;
    assign T2          = r_T2;
    assign C3          = r_C3;
    assign T3          = r_T3;
    assign C4          = r_C4;
    assign T4          = r_T4;
    assign C5          = r_C5;
    assign T5          = r_T5;
    assign v2          = r_v2;
    assign v3          = r_v3;
    assign v4          = r_v4;
    assign v5          = r_v5;
    assign fetch_stall = w_stall;
    assign stall_cnt   = r_stall_cnt;
    assign retire_cnt  = r_retire_cnt;
    assign hold_err    = r_hold_err;

endmodule
